// File: rtl/mul_share_ctrl.sv
// Sequencing controller for one shared shift-free multiplier datapath (P += A, B times),
// arbitrating between two requesters and pulsing done to whichever one owned the operation.
module mul_share_ctrl #(
    parameter int RR = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic eqz,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic lda,
    output logic ldb,
    output logic ldp,
    output logic clrp,
    output logic decb,
    output logic done0,
    output logic done1,
    output logic busy
);

    // state | meaning
    // IDLE  | no operation; arbitrate incoming requests
    // LDA   | load A from the owner's operands
    // LDB   | load B from the owner's operands, clear P
    // ADD   | P <= P + A and B <= B - 1 each cycle until B reaches zero
    // DONE  | one-cycle completion pulse to the owner
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   ptr_q, ptr_d;
    logic   winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        sel     = 1'b0;
        lda     = 1'b0;
        ldb     = 1'b0;
        ldp     = 1'b0;
        clrp    = 1'b0;
        decb    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        busy    = 1'b0;

        // ptr_q names the requester favoured on the next contested grant
        winner = (req0 && req1) ? ((RR != 0) ? ptr_q : 1'b0) : req1;

        if (state_q != IDLE) begin
            gnt0 = ~owner_q;
            gnt1 = owner_q;
            sel  = owner_q;
            busy = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = LDA;
                    owner_d = winner;
                    ptr_d   = ~winner;
                end
            end
            LDA: begin
                lda     = 1'b1;
                state_d = LDB;
            end
            LDB: begin
                ldb     = 1'b1;
                clrp    = 1'b1;
                state_d = ADD;
            end
            ADD: begin
                ldp  = ~eqz;
                decb = ~eqz;
                if (eqz) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done0   = ~owner_q;
                done1   = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: round-robin and fixed-priority instances side by side, each with a
// behavioural multiply datapath, checked every cycle against an operation-timeline model.
module tb_mul_share_ctrl;

    logic clk;
    logic rst;
    logic req0;
    logic req1;

    logic [1:0] eqz_w, gnt0_w, gnt1_w, sel_w, lda_w, ldb_w, ldp_w, clrp_w, decb_w;
    logic [1:0] done0_w, done1_w, busy_w;

    logic [7:0]  op_a [2];
    logic [7:0]  op_b [2];
    logic [7:0]  a_r  [2];
    logic [7:0]  b_r  [2];
    logic [15:0] p_r  [2];

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en;

    // model: per instance, whether an operation is in flight and its cycle offset since the grant
    bit         m_act [2];
    bit         m_own [2];
    bit         m_fav [2];
    int         m_t   [2];
    logic [7:0] m_a   [2];
    logic [7:0] m_b   [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mul_share_ctrl #(.RR(1)) dut_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .eqz(eqz_w[0]),
        .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .sel(sel_w[0]),
        .lda(lda_w[0]), .ldb(ldb_w[0]), .ldp(ldp_w[0]), .clrp(clrp_w[0]), .decb(decb_w[0]),
        .done0(done0_w[0]), .done1(done1_w[0]), .busy(busy_w[0])
    );

    mul_share_ctrl #(.RR(0)) dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .eqz(eqz_w[1]),
        .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .sel(sel_w[1]),
        .lda(lda_w[1]), .ldb(ldb_w[1]), .ldp(ldp_w[1]), .clrp(clrp_w[1]), .decb(decb_w[1]),
        .done0(done0_w[1]), .done1(done1_w[1]), .busy(busy_w[1])
    );

    assign eqz_w[0] = (b_r[0] == 8'd0);
    assign eqz_w[1] = (b_r[1] == 8'd0);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                a_r[i] <= '0;
                b_r[i] <= '0;
                p_r[i] <= '0;
            end else begin
                if (lda_w[i]) a_r[i] <= op_a[sel_w[i]];
                if (ldb_w[i]) b_r[i] <= op_b[sel_w[i]];
                else if (decb_w[i]) b_r[i] <= b_r[i] - 8'd1;
                if (clrp_w[i]) p_r[i] <= '0;
                else if (ldp_w[i]) p_r[i] <= p_r[i] + 16'(a_r[i]);
            end
        end
    end

    function automatic bit pick(input int i);
        if (req0 && req1) return (i == 0) ? m_fav[i] : 1'b0;
        return req1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
                m_fav[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (m_t[i] == 4 + int'(m_b[i])) m_act[i] <= 1'b0;
                else m_t[i] <= m_t[i] + 1;
            end else if (req0 || req1) begin
                m_act[i] <= 1'b1;
                m_t[i]   <= 1;
                m_own[i] <= pick(i);
                m_fav[i] <= !pick(i);
                m_a[i]   <= op_a[pick(i)];
                m_b[i]   <= op_b[pick(i)];
            end
        end
    end

    // {gnt0, gnt1, sel, lda, ldb, ldp, clrp, decb, done0, done1, busy}
    function automatic logic [10:0] exp_vec(input int i);
        logic [10:0] v;
        int t, b;
        v = '0;
        if (m_act[i]) begin
            t = m_t[i];
            b = int'(m_b[i]);
            v[10] = !m_own[i];
            v[9]  = m_own[i];
            v[8]  = m_own[i];
            v[7]  = (t == 1);
            v[6]  = (t == 2);
            v[5]  = (t >= 3) && (t <= 2 + b);
            v[4]  = (t == 2);
            v[3]  = (t >= 3) && (t <= 2 + b);
            v[2]  = (t == 4 + b) && !m_own[i];
            v[1]  = (t == 4 + b) && m_own[i];
            v[0]  = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [10:0] act_vec(input int i);
        return {gnt0_w[i], gnt1_w[i], sel_w[i], lda_w[i], ldb_w[i], ldp_w[i], clrp_w[i],
                decb_w[i], done0_w[i], done1_w[i], busy_w[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("outs_%0d", i), 32'(act_vec(i)), 32'(exp_vec(i)));
                if (m_act[i] && m_t[i] == 4 + int'(m_b[i]))
                    chk($sformatf("product_%0d", i), 32'(p_r[i]), 32'(16'(m_a[i]) * 16'(m_b[i])));
            end
        end
    end

    task automatic run_single(input int who, input logic [7:0] a, input logic [7:0] b,
                              input int exp_lat, input logic [15:0] exp_p, input bit drop_in_ldb);
        int lat, pulses, got_lat;
        logic [15:0] got_p;
        op_a[who] = a;
        op_b[who] = b;
        if (who == 0) req0 = 1'b1;
        else req1 = 1'b1;
        lat = 0;
        pulses = 0;
        got_lat = -1;
        got_p = '0;
        @(posedge clk);
        while (lat < 40 && got_lat < 0) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("lda_at_k1", 32'(lda_w[0]), 32'd1);
            if (lat == (drop_in_ldb ? 2 : 1)) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (ldp_w[0]) pulses++;
            if (who == 0 ? done0_w[0] : done1_w[0]) begin
                got_lat = lat;
                got_p = p_r[0];
            end
        end
        chk("done_latency", got_lat, exp_lat);
        chk("ldp_pulses", pulses, 32'(b));
        chk("product_lit", 32'(got_p), 32'(exp_p));
        @(negedge clk);
        chk("gnt_after_done", 32'(who == 0 ? gnt0_w[0] : gnt1_w[0]), 32'd0);
        chk("busy_after_done", 32'(busy_w[0]), 32'd0);
    endtask

    task automatic reset_mid_add();
        int n, pulses, dones, busy_seen;
        op_a[0] = 8'd7;
        op_b[0] = 8'd4;
        req0 = 1'b1;
        n = 0;
        pulses = 0;
        while (pulses < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) req0 = 1'b0;
            if (ldp_w[0]) pulses++;
        end
        chk("ldp_before_rst", pulses, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outs_rr", 32'(act_vec(0)), 32'd0);
        chk("rst_outs_fp", 32'(act_vec(1)), 32'd0);
        rst = 1'b0;
        dones = 0;
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            dones += int'(done0_w[0]) + int'(done1_w[0]);
            busy_seen += int'(busy_w[0]);
        end
        chk("no_done_after_rst", dones, 0);
        chk("idle_after_rst", busy_seen, 0);
        run_single(1, 8'd4, 8'd2, 6, 16'd8, 1'b0);
    endtask

    task automatic alternate();
        int own0[$];
        int own1[$];
        int cyc, last_done, n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op_a[0] = 8'd3; op_a[1] = 8'd3;
        op_b[0] = 8'd1; op_b[1] = 8'd1;
        req0 = 1'b1;
        req1 = 1'b1;
        cyc = 0;
        last_done = -100;
        while (own0.size() < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (lda_w[0]) begin
                own0.push_back(int'(gnt1_w[0]));
                if (own0.size() > 1) chk("gap_done_to_lda", cyc - last_done, 2);
            end
            if (lda_w[1]) own1.push_back(int'(gnt1_w[1]));
            if (done0_w[0] || done1_w[0]) last_done = cyc;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rr_count", own0.size(), 4);
        chk("fp_count", own1.size(), 4);
        for (int j = 0; j < own0.size(); j++) chk("rr_grant", own0[j], j % 2);
        for (int j = 0; j < own1.size(); j++) chk("fp_grant", own1[j], 0);
        n = 0;
        while (busy_w != 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_alt", 32'(busy_w), 32'd0);
    endtask

    task automatic random_phase();
        int n;
        repeat (1500) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            req0 = ($urandom_range(0, 1) == 1);
            req1 = ($urandom_range(0, 2) == 0);
            if (!m_act[0] && !m_act[1] && !req0 && !req1) begin
                op_a[0] = 8'($urandom_range(0, 255));
                op_a[1] = 8'($urandom_range(0, 255));
                op_b[0] = 8'($urandom_range(0, 5));
                op_b[1] = 8'($urandom_range(0, 5));
            end
        end
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        n = 0;
        while (busy_w != 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_rand", 32'(busy_w), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs_rr", 32'(act_vec(0)), 32'd0);
        chk("reset_outs_fp", 32'(act_vec(1)), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_single(0, 8'd5, 8'd3, 7, 16'd15, 1'b0);
        run_single(1, 8'd9, 8'd0, 4, 16'd0, 1'b0);
        run_single(0, 8'd6, 8'd2, 6, 16'd12, 1'b1);
        reset_mid_add();
        alternate();
        random_phase();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with req0 winning.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester operation requests, level-sensitive.
REQ-006 eqz  input  1  datapath flag: B register == 0, combinational from the B register.
REQ-007 gnt0, gnt1  output  1 each  requester currently owns the datapath.
REQ-008 sel  output  1  operand mux select (0 = requester 0 operands, 1 = requester 1 operands).
REQ-009 lda, ldb, ldp, clrp, decb  output  1 each  datapath controls: load A, load B, load P (P <= P + A), clear P, decrement B.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-011 busy  output  1  an operation is in progress (any state other than IDLE).

Function
REQ-012 The FSM SHALL have states IDLE, LDA, LDB, ADD and DONE, held in a registered state register.
REQ-013 All outputs SHALL be decoded from the state, the owner register and eqz only; outputs SHALL NOT be driven by delays or by level-sensitive latches.
REQ-014 IDLE: all outputs 0; if req0 or req1 is sampled high, latch the winner into the owner register and go to LDA, else stay.
REQ-015 Arbitration, RR=1: with both requests high, grant the requester that did not win the previous grant; the pointer SHALL update only on a grant.
REQ-016 Arbitration, RR=0: with both requests high, req0 SHALL always win.
REQ-017 LDA: lda=1 for exactly one cycle; then go to LDB.
REQ-018 LDB: ldb=1 and clrp=1 for exactly one cycle; then go to ADD.
REQ-019 ADD: ldp = decb = ~eqz; stay in ADD while eqz=0; go to DONE when eqz=1.
REQ-020 Number of ldp/decb pulses SHALL equal the loaded B value.
REQ-021 B=0 SHALL produce zero ldp/decb pulses and a product of 0.
REQ-022 DONE: done_owner=1 for exactly one cycle; then go to IDLE.
REQ-023 From LDA through DONE inclusive: gnt_owner=1, the other grant 0, sel=owner, busy=1.
REQ-024 Latency: a request sampled in IDLE at edge k SHALL put LDA at cycle k+1 and DONE at cycle k+4+B.
REQ-025 A request that drops mid-operation SHALL be ignored; the operation completes and done is still pulsed.
REQ-026 A new or held request during a busy operation SHALL wait; it is arbitrated in the next IDLE cycle.
REQ-027 A request still high in IDLE after its done SHALL be treated as a new request.
REQ-028 Back-to-back operations SHALL have exactly one IDLE cycle between DONE and the next LDA.
REQ-029 At most one of lda, ldb, ldp, and at most one of done0/done1, SHALL be high in any cycle.

Reset
REQ-030 rst high at a clock edge SHALL force state IDLE, owner 0 and round-robin pointer to favour req0 at the next grant.
REQ-031 During and after reset, every output SHALL be 0 until a new grant.
REQ-032 Reset mid-operation SHALL abort the operation with no done pulse; rst SHALL have priority over all transitions.

Verification
REQ-033 req0 only, B=3, A=5: lda at k+1; ldb and clrp at k+2; ldp/decb high k+3..k+5; done0 at k+7; P=15.
REQ-034 req1 only, B=0: ldb at k+2; no ldp/decb pulses; done1 at k+4; P=0.
REQ-035 RR=1, req0 and req1 held high: grants alternate 0,1,0,1; one IDLE cycle between DONE and the next LDA.
REQ-036 RR=0, both held high: req0 is granted every time; req1 is never granted.
REQ-037 rst asserted in ADD with B=2 remaining: next cycle all outputs 0, state IDLE, no done; a later req1 runs normally.
REQ-038 req0 dropped during LDB: operation completes; done0 still pulses once; gnt0 falls after DONE.
